// File: rtl/da_fir_ctrl.sv
// ============================================================================
//  Module      : da_fir_ctrl
//  Description : Bit-serial sequencer for a 6-tap distributed-arithmetic FIR
//                with an external combinational 6-bit-address coefficient LUT.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module da_fir_ctrl #(
    parameter int DATA_W = 8,
    parameter int LUT_W  = 6,
    parameter int ACC_W  = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [5:0]        lut_addr,
    input  logic [LUT_W-1:0]  lut_data,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_data,
    input  logic              out_ready
);

    localparam int c_TAPS  = 6;
    localparam int c_CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_x [c_TAPS];
    logic [ACC_W-1:0]    r_acc;
    logic [c_CNT_W-1:0]  r_bit_cnt;
    logic                r_out_valid;
    logic [ACC_W-1:0]    r_out_data;
    logic                w_last;
    logic [ACC_W-1:0]    w_lut_ext;
    logic [ACC_W-1:0]    w_p;

    assign w_last    = (r_bit_cnt == c_CNT_W'(DATA_W - 1));
    assign w_lut_ext = {{(ACC_W - LUT_W){lut_data[LUT_W-1]}}, lut_data};
    assign w_p       = w_lut_ext << r_bit_cnt;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    always_comb begin
        lut_addr = '0;
        if (r_state == S_CALC) begin
            for (int k = 0; k < c_TAPS; k++) begin
                lut_addr[k] = r_x[k][r_bit_cnt];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (in_valid)                 w_state_nxt = S_CALC;
                S_CALC:  if (w_last)                   w_state_nxt = S_DONE;
                S_DONE:  if (r_out_valid && out_ready) w_state_nxt = S_IDLE;
                default:                               w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < c_TAPS; k++) begin
                r_x[k] <= '0;
            end
            r_acc       <= '0;
            r_bit_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (clr) begin
            // out_data deliberately keeps its last value across an abort
            for (int k = 0; k < c_TAPS; k++) begin
                r_x[k] <= '0;
            end
            r_acc       <= '0;
            r_bit_cnt   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int k = c_TAPS - 1; k > 0; k--) begin
                            r_x[k] <= r_x[k-1];
                        end
                        r_x[0]    <= in_data;
                        r_acc     <= '0;
                        r_bit_cnt <= '0;
                    end
                end
                S_CALC: begin
                    // MSB carries negative weight in two's complement
                    if (w_last) begin
                        r_acc <= r_acc - w_p;
                    end else begin
                        r_acc     <= r_acc + w_p;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (!r_out_valid) begin
                        r_out_data  <= r_acc;
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_da_fir_ctrl.sv
// ============================================================================
//  Module      : tb_da_fir_ctrl
//  Description : Self-checking bench for da_fir_ctrl with a behavioural LUT.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_da_fir_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [5:0]  lut_addr;
    logic [5:0]  lut_data;
    logic        out_valid;
    logic [13:0] out_data;
    logic        out_ready;

    int total = 0;
    int bad   = 0;

    int c_h [6] = '{7, -7, 5, 5, -5, 3};
    int hist [6];

    da_fir_ctrl #(.DATA_W(8), .LUT_W(6), .ACC_W(14)) dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .lut_addr  (lut_addr),
        .lut_data  (lut_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    always_comb begin
        int s;
        s = 0;
        for (int k = 0; k < 6; k++) begin
            if (lut_addr[k]) s = s + c_h[k];
        end
        lut_data = 6'(s);
    end

    typedef struct {
        bit         rst_before;
        logic [7:0] sample;
        int         exp;
    } vec_t;

    vec_t vecs [21];

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 6; k++) hist[k] = 0;
    endtask

    task automatic model_push(input logic [7:0] s);
        for (int k = 5; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = int'($signed(s));
    endtask

    function automatic int model_y();
        int acc;
        acc = 0;
        for (int k = 0; k < 6; k++) acc = acc + c_h[k] * hist[k];
        return acc;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        model_clear();
    endtask

    // Called at a negedge; returns the result and cycles from accept to out_valid
    task automatic do_sample(input logic [7:0] s, input bit rnd,
                             output logic signed [13:0] y, output int lat, output bit got);
        int          n;
        bit          prev_v;
        logic [13:0] held;
        n   = 0;
        got = 1'b0;
        lat = -1;
        y   = '0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check_int("in_ready_timeout", 0, 1);
            return;
        end
        in_valid = 1'b1;
        in_data  = s;
        @(negedge clk);
        in_valid = 1'b0;
        prev_v   = 1'b0;
        held     = '0;
        for (int i = 0; i < 60 && !got; i++) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid) begin
                if (lat < 0) lat = i;
                if (prev_v) check_int("stall_hold", int'(out_data), int'(held));
                held   = out_data;
                prev_v = 1'b1;
                if (out_ready) begin
                    y   = out_data;
                    got = 1'b1;
                end
            end
            if (rnd && !got) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 8'($urandom);
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (!got) check_int("result_timeout", 0, 1);
    endtask

    task automatic abort_test(input bit use_reset);
        logic signed [13:0] y;
        int                 lat;
        bit                 got;
        int                 seen;
        do_reset();
        do_sample(8'h01, 1'b0, y, lat, got);
        check_int("abort_pre1", int'(y), 7);
        do_sample(8'h01, 1'b0, y, lat, got);
        check_int("abort_pre2", int'(y), 0);
        in_valid = 1'b1;
        in_data  = 8'h01;
        @(negedge clk);
        in_valid = 1'b0;
        check_int("lut_addr_bit0", int'(lut_addr), 7);
        @(negedge clk);
        check_int("lut_addr_bit1", int'(lut_addr), 0);
        @(negedge clk);
        if (use_reset) reset = 1'b1;
        else           clr   = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        clr   = 1'b0;
        check_int(use_reset ? "rst_abort_in_ready" : "clr_abort_in_ready", int'(in_ready), 1);
        check_int(use_reset ? "rst_abort_out_valid" : "clr_abort_out_valid", int'(out_valid), 0);
        if (use_reset) check_int("rst_abort_out_data", int'(out_data), 0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen = 1;
            @(negedge clk);
        end
        check_int("abort_no_result", seen, 0);
        do_sample(8'h01, 1'b0, y, lat, got);
        check_int(use_reset ? "rst_abort_after" : "clr_abort_after", int'(y), 7);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [13:0] y;
        int                 lat;
        bit                 got;
        int                 n;
        logic [7:0]         s;

        vecs[0]  = '{1'b1, 8'h01, 7};
        vecs[1]  = '{1'b0, 8'h00, -7};
        vecs[2]  = '{1'b0, 8'h00, 5};
        vecs[3]  = '{1'b0, 8'h00, 5};
        vecs[4]  = '{1'b0, 8'h00, -5};
        vecs[5]  = '{1'b0, 8'h00, 3};
        vecs[6]  = '{1'b0, 8'h00, 0};
        vecs[7]  = '{1'b1, 8'hFF, -7};
        vecs[8]  = '{1'b0, 8'h80, -889};
        vecs[9]  = '{1'b1, 8'h80, -896};
        vecs[10] = '{1'b0, 8'h80, 0};
        vecs[11] = '{1'b0, 8'h80, -640};
        vecs[12] = '{1'b0, 8'h80, -1280};
        vecs[13] = '{1'b0, 8'h80, -640};
        vecs[14] = '{1'b0, 8'h80, -1024};
        vecs[15] = '{1'b1, 8'h7F, 889};
        vecs[16] = '{1'b0, 8'h7F, 0};
        vecs[17] = '{1'b0, 8'h7F, 635};
        vecs[18] = '{1'b0, 8'h7F, 1270};
        vecs[19] = '{1'b0, 8'h7F, 635};
        vecs[20] = '{1'b0, 8'h7F, 1016};

        reset     = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        check_int("reset_in_ready", int'(in_ready), 1);
        check_int("reset_out_valid", int'(out_valid), 0);
        check_int("reset_out_data", int'(out_data), 0);
        check_int("reset_lut_addr", int'(lut_addr), 0);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 21; v++) begin
            if (vecs[v].rst_before) do_reset();
            do_sample(vecs[v].sample, 1'b0, y, lat, got);
            if (got) check_int($sformatf("vec%0d", v), int'(y), vecs[v].exp);
            if (v == 0) check_int("latency", lat, 9);
        end

        // Backpressure: 5 stalled cycles, a sample offered during the stall must be dropped
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h01;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_int("bp_valid_seen", int'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            check_int("bp_out_valid", int'(out_valid), 1);
            check_int("bp_out_data", int'(out_data), 7);
            check_int("bp_in_ready", int'(in_ready), 0);
            in_valid = 1'b1;
            in_data  = 8'h55;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_int("bp_release_valid", int'(out_valid), 0);
        check_int("bp_release_idle", int'(in_ready), 1);
        do_sample(8'h00, 1'b0, y, lat, got);
        check_int("bp_no_capture", int'(y), -7);

        abort_test(1'b0);
        abort_test(1'b1);

        do_reset();
        for (int i = 0; i < 1000; i++) begin
            n = $urandom_range(0, 2);
            for (int g = 0; g < n; g++) @(negedge clk);
            s = 8'($urandom);
            do_sample(s, 1'b1, y, lat, got);
            model_push(s);
            if (got) check_int("random", int'(y), model_y());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
